// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port program/data RAM between the debug loader port and
// the CPU data port. Writes complete in the grant cycle; reads hold the
// arbiter in RD_WAIT for one cycle while the RAM returns the word. While a
// debug session is active the CPU is held in reset (cpu_run low) and its
// requests are ignored. Accesses outside the RAM window are acknowledged,
// flagged on err, never reach the RAM, and reads among them return zero.
//
// Parameters
//   BASE        byte address of RAM word 0
//   AW          RAM word-address width (RAM spans BASE .. BASE + 4*2^AW - 1)
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   dbg_session             debug loader owns the system, CPU held
//   dbg_req/adr/wren/wdata  debug request (wren == 0 means read)
//   dbg_ack                 one-cycle pulse when the debug access is issued
//   dbg_rvalid/rdata        debug read return (rdata held between reads)
//   cpu_*                   CPU port, same semantics as the debug port
//   cpu_run                 registered CPU reset release
//   mem_cs/adr/wren/wdata   RAM strobe, word address, byte enables, data
//   mem_rdata               RAM read data, valid the cycle after a read strobe
//   err                     one-cycle pulse on an out-of-range access
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter logic [31:0] BASE = 32'h0,
    parameter int unsigned AW   = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          dbg_session,
    input  logic          dbg_req,
    input  logic [31:0]   dbg_adr,
    input  logic [3:0]    dbg_wren,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,

    input  logic          cpu_req,
    input  logic [31:0]   cpu_adr,
    input  logic [3:0]    cpu_wren,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_run,

    output logic          mem_cs,
    output logic [AW-1:0] mem_adr,
    output logic [3:0]    mem_wren,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic          err
);

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_DBG
    } port_t;

    // Registered state
    state_t      state_q,      state_d;
    port_t       last_grant_q, last_grant_d;
    port_t       owner_q,      owner_d;       // master waiting for read data
    logic        rd_err_q,     rd_err_d;      // pending read was out of range
    logic        cpu_run_q,    cpu_run_d;
    logic        quiet_q,      quiet_d;       // previous cycle was quiet
    logic [31:0] dbg_rdata_q,  dbg_rdata_d;
    logic [31:0] cpu_rdata_q,  cpu_rdata_d;

    // Grant-path signals
    logic        cpu_elig;
    logic        grant;
    logic        grant_dbg;
    logic [31:0] sel_word;
    logic [31:0] sel_off;
    logic [3:0]  sel_wren;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic        is_read;
    logic        quiet_now;
    logic [31:0] rd_word;

    // Byte-offset bits of word-aligned addresses carry no information.
    logic        adr_lsb_unused;
    assign adr_lsb_unused = ^{dbg_adr[1:0], cpu_adr[1:0]};

    // -------------------------------------------------------------------------
    // Arbitration and RAM drive (combinational, only in IDLE)
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cpu_elig  = cpu_req && !dbg_session && cpu_run_q;
        grant     = 1'b0;
        grant_dbg = 1'b0;

        // Grants are suppressed while reset is asserted so every output
        // shows its reset value even if requests are already present.
        if (state_q == ST_IDLE && !reset) begin
            if (dbg_req && cpu_elig) begin
                grant     = 1'b1;
                grant_dbg = (last_grant_q == PORT_CPU);
            end else if (dbg_req) begin
                grant     = 1'b1;
                grant_dbg = 1'b1;
            end else if (cpu_elig) begin
                grant     = 1'b1;
            end
        end

        sel_word  = grant_dbg ? {dbg_adr[31:2], 2'b00} : {cpu_adr[31:2], 2'b00};
        sel_wren  = grant_dbg ? dbg_wren  : cpu_wren;
        sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
        sel_off   = sel_word - BASE;

        // Range check on the full 32-bit offset before truncating to AW bits;
        // shifting the offset avoids overflow in BASE + 4*2^AW.
        in_range  = (sel_word >= BASE) && ((sel_off >> (AW + 2)) == 32'd0);
        is_read   = (sel_wren == 4'h0);

        dbg_ack   = grant && grant_dbg;
        cpu_ack   = grant && !grant_dbg;
        err       = grant && !in_range;
        mem_cs    = grant && in_range;
        mem_adr   = mem_cs ? sel_off[AW+1:2] : '0;
        mem_wren  = mem_cs ? sel_wren  : 4'h0;
        mem_wdata = mem_cs ? sel_wdata : 32'h0;
    end

    // -------------------------------------------------------------------------
    // FSM next state, read return and CPU hold
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rd_err_d     = rd_err_q;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rvalid   = 1'b0;
        cpu_rvalid   = 1'b0;

        // An absorbed out-of-range read returns zero, not whatever the RAM
        // happens to drive.
        rd_word = rd_err_q ? 32'h0 : mem_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    last_grant_d = grant_dbg ? PORT_DBG : PORT_CPU;
                    if (is_read) begin
                        state_d  = ST_RD_WAIT;
                        owner_d  = grant_dbg ? PORT_DBG : PORT_CPU;
                        rd_err_d = !in_range;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_IDLE;
                if (owner_q == PORT_DBG) begin
                    dbg_rvalid  = 1'b1;
                    dbg_rdata_d = rd_word;
                end else begin
                    cpu_rvalid  = 1'b1;
                    cpu_rdata_d = rd_word;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data is presented in the rvalid cycle and then held.
        dbg_rdata = dbg_rdata_d;
        cpu_rdata = cpu_rdata_d;

        // The CPU is released only after two consecutive quiet cycles
        // (no session, arbiter idle, no debug request); a session drops it
        // the following cycle regardless of what the arbiter is doing.
        quiet_now = !dbg_session && (state_q == ST_IDLE) && !dbg_req;
        quiet_d   = quiet_now;
        cpu_run_d = !dbg_session && (cpu_run_q || (quiet_now && quiet_q));
    end

    assign cpu_run = cpu_run_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_CPU;
            owner_q      <= PORT_CPU;
            rd_err_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            quiet_q      <= 1'b0;
            dbg_rdata_q  <= 32'h0;
            cpu_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_err_q     <= rd_err_d;
            cpu_run_q    <= cpu_run_d;
            quiet_q      <= quiet_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter with a small RAM window (BASE = 0x100, 16 words) so that
// addresses both below and above the window are reachable. A stand-in RAM
// macro answers the mem_* strobes. A behavioural model, kept in terms of
// requests, grants, a shadow memory and a pending-read slot, predicts every
// output on every cycle; directed sequences pin the model with literal values.
// Addresses in the directed sequences are given relative to BASE.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          dbg_session;
    logic          dbg_req;
    logic [31:0]   dbg_adr;
    logic [3:0]    dbg_wren;
    logic [31:0]   dbg_wdata;
    logic          dbg_ack;
    logic          dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic          cpu_req;
    logic [31:0]   cpu_adr;
    logic [3:0]    cpu_wren;
    logic [31:0]   cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          cpu_run;
    logic          mem_cs;
    logic [AW-1:0] mem_adr;
    logic [3:0]    mem_wren;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter #(.BASE(BASE), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .dbg_session(dbg_session),
        .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_wren(dbg_wren), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_wren(cpu_wren), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_run(cpu_run),
        .mem_cs(mem_cs), .mem_adr(mem_adr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err(err)
    );

    // Stand-in RAM macro: data the cycle after a read strobe, garbage otherwise.
    logic [31:0] ram [DEPTH] = '{default: 32'h0};

    always @(posedge clk) begin
        if (mem_cs && mem_wren == 4'h0) begin
            mem_rdata <= ram[mem_adr];
        end else begin
            mem_rdata <= $urandom;
        end
        if (mem_cs) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wren[b]) ram[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: evaluated at every falling edge
    // -------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH] = '{default: 32'h0};
    logic        m_pend;
    logic        m_pend_dbg;
    logic [31:0] m_pend_data;
    logic        m_last_dbg;
    logic        m_run;
    int          m_quiet;
    logic [31:0] m_rd_dbg;
    logic [31:0] m_rd_cpu;

    initial begin : model
        logic        e_dack, e_cack, e_drv, e_crv, e_cs, e_err;
        logic [3:0]  e_wren;
        logic [31:0] e_adr, e_wd;
        logic        was_pend, cpu_ok, use_dbg, in_rng;
        logic [31:0] a_adr, a_wd;
        logic [3:0]  a_wren;
        longint      word;
        int          idx;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_dbg_ack",    32'(dbg_ack),    32'h0);
                check("rst_cpu_ack",    32'(cpu_ack),    32'h0);
                check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
                check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
                check("rst_mem_cs",     32'(mem_cs),     32'h0);
                check("rst_mem_wren",   32'(mem_wren),   32'h0);
                check("rst_err",        32'(err),        32'h0);
                check("rst_cpu_run",    32'(cpu_run),    32'h0);
                check("rst_dbg_rdata",  dbg_rdata,       32'h0);
                check("rst_cpu_rdata",  cpu_rdata,       32'h0);
                m_pend     = 1'b0;
                m_last_dbg = 1'b0;
                m_run      = 1'b0;
                m_quiet    = 0;
                m_rd_dbg   = 32'h0;
                m_rd_cpu   = 32'h0;
            end else begin
                e_dack = 0; e_cack = 0; e_drv = 0; e_crv = 0; e_cs = 0; e_err = 0;
                e_wren = 4'h0; e_adr = 32'h0; e_wd = 32'h0;
                was_pend = m_pend;
                if (m_pend) begin
                    // A read granted last cycle returns now; nobody is granted.
                    if (m_pend_dbg) begin
                        e_drv    = 1'b1;
                        m_rd_dbg = m_pend_data;
                    end else begin
                        e_crv    = 1'b1;
                        m_rd_cpu = m_pend_data;
                    end
                    m_pend = 1'b0;
                end else begin
                    cpu_ok = cpu_req && !dbg_session && m_run;
                    if (dbg_req || cpu_ok) begin
                        // On a tie the port that did not win last time goes.
                        use_dbg = dbg_req && !(cpu_ok && m_last_dbg);
                        a_adr   = use_dbg ? dbg_adr   : cpu_adr;
                        a_wren  = use_dbg ? dbg_wren  : cpu_wren;
                        a_wd    = use_dbg ? dbg_wdata : cpu_wdata;
                        word    = longint'(a_adr) - longint'(a_adr % 4);
                        in_rng  = (word >= longint'(BASE)) &&
                                  (word <  longint'(BASE) + 4 * DEPTH);
                        idx     = in_rng ? int'((word - longint'(BASE)) / 4) : 0;
                        e_dack  = use_dbg;
                        e_cack  = !use_dbg;
                        e_err   = !in_rng;
                        e_cs    = in_rng;
                        if (in_rng) begin
                            e_wren = a_wren;
                            e_adr  = 32'(idx);
                            e_wd   = a_wd;
                        end
                        if (a_wren == 4'h0) begin
                            m_pend      = 1'b1;
                            m_pend_dbg  = use_dbg;
                            m_pend_data = in_rng ? m_mem[idx] : 32'h0;
                        end else if (in_rng) begin
                            for (int b = 0; b < 4; b++) begin
                                if (a_wren[b]) m_mem[idx][8*b +: 8] = a_wd[8*b +: 8];
                            end
                        end
                        m_last_dbg = use_dbg;
                    end
                end

                check("mdl_dbg_ack",    32'(dbg_ack),    32'(e_dack));
                check("mdl_cpu_ack",    32'(cpu_ack),    32'(e_cack));
                check("mdl_dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
                check("mdl_cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
                check("mdl_dbg_rdata",  dbg_rdata,       m_rd_dbg);
                check("mdl_cpu_rdata",  cpu_rdata,       m_rd_cpu);
                check("mdl_err",        32'(err),        32'(e_err));
                check("mdl_mem_cs",     32'(mem_cs),     32'(e_cs));
                check("mdl_mem_wren",   32'(mem_wren),   32'(e_wren));
                check("mdl_cpu_run",    32'(cpu_run),    32'(m_run));
                if (e_cs) begin
                    check("mdl_mem_adr",   32'(mem_adr), e_adr);
                    check("mdl_mem_wdata", mem_wdata,    e_wd);
                end

                // CPU release: two consecutive quiet cycles, cleared by a session.
                if (dbg_session) begin
                    m_run   = 1'b0;
                    m_quiet = 0;
                end else if (!was_pend && !dbg_req) begin
                    m_quiet++;
                    if (m_quiet >= 2) m_run = 1'b1;
                end else begin
                    m_quiet = 0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    function automatic logic [31:0] rand_adr();
        int          k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        if (k < 8)       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
        else if (k == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
        else             a = ($urandom_range(0, 1) == 1) ? BASE - 4 : 32'hFFFF_FFFC;
        return a;
    endfunction

    function automatic logic [3:0] rand_wren();
        return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic d_acked, c_acked;
        reset = 1'b1; dbg_session = 1'b0;
        dbg_req = 1'b0; dbg_adr = 32'h0; dbg_wren = 4'h0; dbg_wdata = 32'h0;
        cpu_req = 1'b0; cpu_adr = 32'h0; cpu_wren = 4'h0; cpu_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cpu_run",   32'(cpu_run), 32'h0);
        check("reset_mem_cs",    32'(mem_cs),  32'h0);
        check("reset_dbg_rdata", dbg_rdata,    32'h0);
        next_cycle();
        reset = 1'b0; dbg_session = 1'b1;

        // Byte-lane writes then a full-word read.
        next_cycle();
        dbg_req = 1'b1; dbg_adr = BASE + 32'hC; dbg_wren = 4'b0001; dbg_wdata = 32'h32;
        @(negedge clk);
        check("lane_ack0",  32'(dbg_ack),  32'h1);
        check("lane_wren0", 32'(mem_wren), 32'h1);
        check("lane_adr0",  32'(mem_adr),  32'h3);
        next_cycle();
        dbg_wren = 4'b0010; dbg_wdata = 32'h3100;
        @(negedge clk);
        check("lane_ack1",  32'(dbg_ack),  32'h1);
        check("lane_wren1", 32'(mem_wren), 32'h2);
        next_cycle();
        dbg_wren = 4'h0;
        @(negedge clk);
        check("lane_rd_ack",    32'(dbg_ack),    32'h1);
        check("lane_rd_rvalid", 32'(dbg_rvalid), 32'h0);
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        check("lane_rvalid", 32'(dbg_rvalid), 32'h1);
        check("lane_rdata",  dbg_rdata,       32'h0000_3132);

        // Session hold: CPU request ignored, release two cycles after drop.
        next_cycle();
        cpu_req = 1'b1; cpu_adr = BASE + 32'h8; cpu_wren = 4'hF; cpu_wdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_cpu_ack", 32'(cpu_ack), 32'h0);
            check("hold_cpu_run", 32'(cpu_run), 32'h0);
            next_cycle();
        end
        dbg_session = 1'b0;
        @(negedge clk);
        check("rel_run_m0", 32'(cpu_run), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rel_run_m1", 32'(cpu_run), 32'h0);
        check("rel_ack_m1", 32'(cpu_ack), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rel_run_m2", 32'(cpu_run), 32'h1);
        check("rel_ack_m2", 32'(cpu_ack), 32'h1);
        next_cycle();

        // Contention: continuous writes from both ports alternate, DBG first.
        dbg_req = 1'b1; dbg_adr = BASE + 32'h4; dbg_wren = 4'hF;
        cpu_req = 1'b1; cpu_adr = BASE + 32'h8; cpu_wren = 4'hF;
        for (int i = 0; i < 6; i++) begin
            dbg_wdata = 32'hD000_0000 + 32'(i);
            cpu_wdata = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
            check("cont_dbg_ack", 32'(dbg_ack), 32'((i % 2) == 0));
            check("cont_cpu_ack", 32'(cpu_ack), 32'((i % 2) == 1));
            next_cycle();
        end
        cpu_req = 1'b0;
        @(negedge clk);
        check("solo_dbg_ack", 32'(dbg_ack), 32'h1);
        next_cycle();

        // CPU read against debug write with the debug port granted last.
        cpu_req = 1'b1; cpu_wren = 4'h0; cpu_adr = BASE + 32'h8;
        dbg_adr = BASE + 32'h10; dbg_wdata = 32'h1122_3344;
        @(negedge clk);
        check("mix_cpu_ack_n", 32'(cpu_ack), 32'h1);
        check("mix_dbg_ack_n", 32'(dbg_ack), 32'h0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("mix_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("mix_cpu_rdata",  cpu_rdata,       32'hC0DE_0005);
        check("mix_dbg_ack_n1", 32'(dbg_ack),    32'h0);
        next_cycle();
        @(negedge clk);
        check("mix_dbg_ack_n2", 32'(dbg_ack), 32'h1);
        next_cycle();

        // Out of range: first word past the window.
        dbg_adr = BASE + 32'h40; dbg_wren = 4'hF; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("oor_wr_err", 32'(err),     32'h1);
        check("oor_wr_cs",  32'(mem_cs),  32'h0);
        check("oor_wr_ack", 32'(dbg_ack), 32'h1);
        next_cycle();
        dbg_wren = 4'h0;
        @(negedge clk);
        check("oor_rd_err", 32'(err),    32'h1);
        check("oor_rd_cs",  32'(mem_cs), 32'h0);
        next_cycle();
        dbg_req = 1'b0;
        @(negedge clk);
        check("oor_rvalid", 32'(dbg_rvalid), 32'h1);
        check("oor_rdata",  dbg_rdata,       32'h0);
        check("oor_err_q",  32'(err),        32'h0);

        // Reset asserted in the read-wait cycle.
        next_cycle();
        dbg_req = 1'b1; dbg_adr = BASE + 32'hC; dbg_wren = 4'h0;
        @(negedge clk);
        check("rmr_ack", 32'(dbg_ack), 32'h1);
        next_cycle();
        dbg_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rmr_rvalid",  32'(dbg_rvalid), 32'h0);
        check("rmr_cpu_run", 32'(cpu_run),    32'h0);
        check("rmr_rdata",   dbg_rdata,       32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rmr_rvalid_after", 32'(dbg_rvalid), 32'h0);
        next_cycle();

        // Randomised traffic: requests held until acked, sessions and resets
        // sprinkled in.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            d_acked = dbg_ack;
            c_acked = cpu_ack;
            next_cycle();
            if (!dbg_req || d_acked) begin
                dbg_req   = ($urandom_range(0, 99) < 40);
                dbg_adr   = rand_adr();
                dbg_wren  = rand_wren();
                dbg_wdata = $urandom;
            end
            if (!cpu_req || c_acked) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_adr   = rand_adr();
                cpu_wren  = rand_wren();
                cpu_wdata = $urandom;
            end
            if ($urandom_range(0, 99) < 3) dbg_session = ~dbg_session;
            reset = ($urandom_range(0, 999) < 3);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
